// File: rtl/fft_ctrl_pkg.sv
// ============================================================================
// Module      : fft_ctrl_pkg
// Description : Shared types, FFT size constants and size sanitizer for the
//               FFT -> magnitude -> pitch-detect chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [9:0] NPOINT_128     = 10'd128;
  localparam logic [9:0] NPOINT_256     = 10'd256;
  localparam logic [9:0] NPOINT_512     = 10'd512;
  localparam logic [9:0] NPOINT_DEFAULT = NPOINT_512;

  localparam int WDOG_W = 16;

  // Unsupported sizes fall back to the largest FFT so no samples are lost.
  function automatic logic [9:0] sanitize_npoint(input logic [9:0] req);
    case (req)
      NPOINT_128, NPOINT_256, NPOINT_512: return req;
      default:                            return NPOINT_DEFAULT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_ctrl_watchdog.sv
// ============================================================================
// Module      : fft_ctrl_watchdog
// Description : 16-bit cycle counter that flags expiry after TIMEOUT_CYCLES
//               enabled cycles since the last clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_ctrl_watchdog
  import fft_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam logic [WDOG_W-1:0] C_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (count_en_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = count_en_i && (count_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
// ============================================================================
// Module      : fft_frame_ctrl
// Description : Gates the ADC sample stream into FFT frames and waits for the
//               pitch result between frames. Optional watchdog on the wait is
//               built when FFT_FRAME_CTRL_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [9:0]  cfg_npoint,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        fft_valid,
  output logic [15:0] fft_data,
  output logic        fft_last,
  output logic [9:0]  fft_npoint,
  input  logic        freq_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_cfg_check
    $error("fft_frame_ctrl: TIMEOUT_CYCLES out of range");
  end

  state_t      state_q;
  logic [9:0]  sample_cnt_q;
  logic [9:0]  npoint_q;
  logic        fft_valid_q;
  logic [15:0] fft_data_q;
  logic        fft_last_q;
  logic        busy_q;
  logic        frame_done_q;
  logic        timeout_err_q;
  logic [15:0] frame_count_q;
  logic [15:0] drop_count_q;

  logic w_last_sample;
  logic w_wdog_expired;

  assign w_last_sample = (state_q == ST_FILL) && s_valid
                      && (sample_cnt_q == (npoint_q - 10'd1));

`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
  fft_ctrl_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .resetn     (resetn),
    .clear_i    (w_last_sample),
    .count_en_i (state_q == ST_WAIT),
    .expired_o  (w_wdog_expired)
  );
`else
  assign w_wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      sample_cnt_q  <= '0;
      npoint_q      <= NPOINT_DEFAULT;
      fft_valid_q   <= 1'b0;
      fft_data_q    <= '0;
      fft_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      fft_valid_q  <= 1'b0;
      fft_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A sample coinciding with the start cycle is neither sent nor dropped.
          if (enable) begin
            npoint_q      <= sanitize_npoint(cfg_npoint);
            sample_cnt_q  <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (s_valid) begin
            fft_valid_q  <= 1'b1;
            fft_data_q   <= s_data;
            sample_cnt_q <= sample_cnt_q + 10'd1;
            if (w_last_sample) begin
              fft_last_q <= 1'b1;
              state_q    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (s_valid && (drop_count_q != 16'hFFFF)) begin
            drop_count_q <= drop_count_q + 16'd1;
          end
          if (freq_valid) begin
            state_q <= ST_DONE;
          end else if (w_wdog_expired) begin
            timeout_err_q <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          frame_done_q  <= 1'b1;
          frame_count_q <= frame_count_q + 16'd1;
          busy_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fft_valid   = fft_valid_q;
  assign fft_data    = fft_data_q;
  assign fft_last    = fft_last_q;
  assign fft_npoint  = npoint_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
// ============================================================================
// Module      : tb_fft_frame_ctrl
// Description : Directed self-checking bench for fft_frame_ctrl; the timeout
//               step follows FFT_FRAME_CTRL_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_frame_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [9:0]  cfg_npoint;
  logic        s_valid;
  logic [15:0] s_data;
  logic        fft_valid;
  logic [15:0] fft_data;
  logic        fft_last;
  logic [9:0]  fft_npoint;
  logic        freq_valid;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  int checks     = 0;
  int failures   = 0;
  int done_seen  = 0;
  int beats      = 0;
  int last_at    = 0;
  int gap        = 0;
  int fwd        = 0;
  int wait_ticks = 0;
  logic [15:0] first_data;
  logic [15:0] last_data;

  fft_frame_ctrl #(
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .cfg_npoint  (cfg_npoint),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .fft_valid   (fft_valid),
    .fft_data    (fft_data),
    .fft_last    (fft_last),
    .fft_npoint  (fft_npoint),
    .freq_valid  (freq_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) done_seen++;
  endtask

  task automatic start_frame(input logic [9:0] cfg);
    cfg_npoint = cfg;
    enable     = 1'b1;
    tick();
    enable     = 1'b0;
  endtask

  // Streams samples base, base+1, ... until fft_last or the budget runs out.
  task automatic run_fill(input int budget, input logic [15:0] base);
    beats = 0; last_at = 0; first_data = '0; last_data = '0;
    s_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      s_data = base + 16'(i);
      tick();
      if (fft_valid) begin
        beats++;
        if (beats == 1) first_data = fft_data;
        if (fft_last) begin
          last_at   = beats;
          last_data = fft_data;
          break;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    resetn = 1'b0; enable = 1'b0; cfg_npoint = '0;
    s_valid = 1'b0; s_data = '0; freq_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_npoint",      32'(fft_npoint),  32'd512);
    check("rst_fft_valid",   32'(fft_valid),   32'd0);
    check("rst_fft_last",    32'(fft_last),    32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_frame_done",  32'(frame_done),  32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_drop_count",  32'(drop_count),  32'd0);
    resetn = 1'b1;
    tick();

    // 128-point frame, start-cycle sample suppressed
    cfg_npoint = 10'd128; enable = 1'b1; s_valid = 1'b1; s_data = 16'hDEAD;
    tick();
    enable = 1'b0;
    check("t1_npoint",         32'(fft_npoint), 32'd128);
    check("t1_start_no_valid", 32'(fft_valid),  32'd0);
    check("t1_busy",           32'(busy),       32'd1);
    run_fill(1000, 16'h1000);
    check("t1_last_beat",  32'(last_at),    32'd128);
    check("t1_first_data", 32'(first_data), 32'h1000);
    check("t1_last_data",  32'(last_data),  32'h107F);
    check("t1_wait_busy",  32'(busy),       32'd1);
    freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0;
    check("t1_done_not_yet", 32'(frame_done),  32'd0);
    tick();
    check("t1_frame_done",   32'(frame_done),  32'd1);
    check("t1_frame_count",  32'(frame_count), 32'd1);
    tick();
    check("t1_done_one_cyc", 32'(frame_done),  32'd0);
    check("t1_idle_busy",    32'(busy),        32'd0);
    check("t1_drop_count",   32'(drop_count),  32'd0);

    // Unsupported size falls back to 512
    start_frame(10'd300);
    check("t2_npoint", 32'(fft_npoint), 32'd512);
    run_fill(1000, 16'h2000);
    check("t2_last_beat", 32'(last_at),   32'd512);
    check("t2_last_data", 32'(last_data), 32'h21FF);
    freq_valid = 1'b1; tick(); freq_valid = 1'b0; tick();
    check("t2_frame_count", 32'(frame_count), 32'd2);

    // Drops in WAIT, cfg change in WAIT not applied to the running frame
    start_frame(10'd256);
    run_fill(1000, 16'h3000);
    check("t3_last_beat", 32'(last_at), 32'd256);
    s_valid = 1'b1; cfg_npoint = 10'd128; fwd = 0;
    for (int i = 0; i < 20; i++) begin
      s_data = 16'h3F00 + 16'(i);
      tick();
      if (fft_valid) fwd++;
    end
    s_valid = 1'b0;
    check("t3_forwarded_in_wait", 32'(fwd),        32'd0);
    check("t3_drop_count",        32'(drop_count), 32'd20);
    check("t3_npoint_held",       32'(fft_npoint), 32'd256);
    freq_valid = 1'b1; tick(); freq_valid = 1'b0; tick();
    check("t3_frame_count", 32'(frame_count), 32'd3);
    start_frame(10'd128);
    check("t3_next_npoint", 32'(fft_npoint), 32'd128);
    run_fill(1000, 16'h4000);
    check("t3_next_last_beat", 32'(last_at), 32'd128);

    // Back-to-back turnaround with enable and s_valid held high
    cfg_npoint = 10'd256; enable = 1'b1; s_valid = 1'b1; s_data = 16'h5000;
    freq_valid = 1'b1; gap = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      freq_valid = 1'b0;
      if (fft_valid) begin
        gap = i;
        break;
      end
    end
    enable = 1'b0;
    check("ta_gap",         32'(gap),         32'd4);
    check("ta_first_data",  32'(fft_data),    32'h5000);
    check("ta_drop_count",  32'(drop_count),  32'd21);
    check("ta_frame_count", 32'(frame_count), 32'd4);
    check("ta_npoint",      32'(fft_npoint),  32'd256);

    // Asynchronous reset at beat 50 of the 256-point frame
    beats = 1;
    for (int i = 1; i < 50; i++) begin
      s_data = 16'h5000 + 16'(i);
      tick();
      if (fft_valid) beats++;
    end
    check("t5_beats_before_reset", 32'(beats), 32'd50);
    #2;
    resetn  = 1'b0;
    s_valid = 1'b0;
    #1;
    check("t5_npoint",      32'(fft_npoint),  32'd512);
    check("t5_fft_valid",   32'(fft_valid),   32'd0);
    check("t5_busy",        32'(busy),        32'd0);
    check("t5_frame_count", 32'(frame_count), 32'd0);
    check("t5_drop_count",  32'(drop_count),  32'd0);
    tick(); tick();
    check("t5_no_frame_done", 32'(done_seen), 32'd4);
    resetn = 1'b1;
    tick();
    start_frame(10'd128);
    check("t5_timeout_err", 32'(timeout_err), 32'd0);
    run_fill(1000, 16'h6000);
    check("t5_last_beat",  32'(last_at),    32'd128);
    check("t5_first_data", 32'(first_data), 32'h6000);

    // No pitch result after the frame
`ifdef FFT_FRAME_CTRL_WATCHDOG_EN
    wait_ticks = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (frame_done) begin
        wait_ticks = i;
        break;
      end
    end
    check("t4_done_latency", 32'(wait_ticks),  32'd101);
    check("t4_timeout_err",  32'(timeout_err), 32'd1);
    check("t4_frame_count",  32'(frame_count), 32'd1);
    tick();
    start_frame(10'd128);
    check("t4_err_cleared", 32'(timeout_err), 32'd0);
`else
    repeat (150) tick();
    check("t4_still_busy",  32'(busy),        32'd1);
    check("t4_no_done",     32'(done_seen),   32'd4);
    check("t4_timeout_err", 32'(timeout_err), 32'd0);
    freq_valid = 1'b1; tick(); freq_valid = 1'b0; tick();
    check("t4_frame_count", 32'(frame_count), 32'd1);
    start_frame(10'd128);
`endif
    run_fill(1000, 16'h7000);
    check("t6_last_beat", 32'(last_at), 32'd128);

    // freq_valid lands on the timeout cycle
    repeat (99) tick();
    freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0;
    check("t6_timeout_err", 32'(timeout_err), 32'd0);
    check("t6_busy",        32'(busy),        32'd1);
    tick();
    check("t6_frame_done",  32'(frame_done),  32'd1);
    check("t6_frame_count", 32'(frame_count), 32'd2);
    tick();
    check("t6_done_once",   32'(done_seen),   32'd6);
    check("t6_err_final",   32'(timeout_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

- Frame sequencer in front of the FFT → magnitude → pitch-detect chain.
- Gates the 48 kHz ADC sample stream into FFT frames of the configured size and generates the frame `last` marker.
- Latches the FFT point count so it stays constant for the whole frame.
- Waits for the pitch detector's result before opening the next frame, and bounds that wait with a watchdog.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 65535: watchdog limit in clocks for the WAIT state. Range 1..65535.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `enable`  in  1  allows a new frame to start; sampled only in IDLE.
- `cfg_npoint`  in  10  requested FFT size (128/256/512).
- `s_valid`  in  1  ADC sample strobe.
- `s_data`  in  16  ADC sample.
- `fft_valid`  out  1  sample to FFT.
- `fft_data`  out  16  sample to FFT.
- `fft_last`  out  1  final sample of frame, qualified by `fft_valid`.
- `fft_npoint`  out  10  active FFT size; drives the FFT and the pitch detector.
- `freq_valid`  in  1  result strobe from the pitch detector; marks frame complete.
- `busy`  out  1  high in FILL, WAIT and DONE.
- `frame_done`  out  1  one-cycle pulse per completed or aborted frame.
- `timeout_err`  out  1  the last frame ended by watchdog.
- `frame_count`  out  16  completed frames, wraps.
- `drop_count`  out  16  samples discarded in WAIT, saturates at 0xFFFF.

## Operation

States:
- **IDLE**
  - `enable`=1: latch the sanitized `cfg_npoint` into `fft_npoint`, clear the sample counter, clear `timeout_err`, go to FILL.
  - Sanitizing: 128, 256 or 512 pass through unchanged; any other value becomes 512.
  - An `s_valid` in the IDLE→FILL transition cycle is not forwarded and is not counted as a drop.
- **FILL**
  - Each `s_valid` is forwarded and increments the sample counter (10 bits).
  - On the sample with counter == `fft_npoint`−1: assert `fft_last`, clear the watchdog, go to WAIT.
  - `freq_valid` in FILL is ignored.
- **WAIT**
  - Each `s_valid` is discarded; `drop_count` increments, saturating at 0xFFFF.
  - `freq_valid`=1: go to DONE.
  - Watchdog reaches `TIMEOUT_CYCLES` (see Configuration) with no `freq_valid`: set `timeout_err`, go to DONE.
  - If `freq_valid` and the timeout occur in the same cycle, `freq_valid` wins and `timeout_err` stays 0.
- **DONE**
  - Pulse `frame_done`.
  - `frame_count` += 1, wrapping 0xFFFF→0.
  - Go to IDLE unconditionally.

Other rules:
- `enable` deasserted mid-frame does not abort; the frame runs to DONE.
- `fft_npoint` changes only on the IDLE→FILL transition. `cfg_npoint` changes at any other time have no effect on the frame in flight.

## Timing

- Reset values: all outputs 0, except `fft_npoint` = 512. State = IDLE.
- Reset is asynchronous and may be asserted mid-frame. The partial frame is abandoned, with no `fft_last` and no `frame_done`.
- `fft_valid`, `fft_data` and `fft_last` are registered, one cycle after `s_valid`/`s_data`.
- `frame_done` rises 2 cycles after `freq_valid` is sampled in WAIT: WAIT→DONE, then the registered pulse.
- Minimum frame turnaround, from `fft_last` to the first forwarded sample of the next frame: 4 cycles, with `enable` held high.
- The watchdog counts cycles spent in WAIT, starting at 0 on FILL→WAIT. The timeout fires when count == `TIMEOUT_CYCLES`−1.

## Configuration

Macro: `FFT_FRAME_CTRL_WATCHDOG_EN`.
- **Defined:** watchdog built as described above; `timeout_err` is live.
- **Undefined:** no watchdog logic; WAIT leaves only on `freq_valid`; `timeout_err` is tied to 0; `TIMEOUT_CYCLES` is unused.

## Structure

- Shared package `fft_ctrl_pkg` holds:
  - state enum (IDLE/FILL/WAIT/DONE),
  - constants `NPOINT_128/256/512` and the default size,
  - function `sanitize_npoint`.
- The pitch detector and FFT wrapper reuse these constants.
- One sub-module, `fft_ctrl_watchdog`:
  - ports: clear, count-enable, expired;
  - 16-bit counter;
  - instantiated only under the macro.

## Test plan

1. `cfg_npoint`=128, `enable`=1, continuous `s_valid` → exactly 128 `fft_valid` beats with `fft_last` on beat 128, `fft_npoint`=128; `freq_valid` pulse → `frame_done` 2 cycles later, `frame_count`=1.
2. `cfg_npoint`=300 → `fft_npoint`=512, `fft_last` on beat 512.
3. 20 samples arrive during WAIT → `drop_count`=20, none forwarded; `cfg_npoint` changed 256→128 during WAIT → next frame uses 128.
4. Watchdog on, `TIMEOUT_CYCLES`=100, no `freq_valid` → `timeout_err`=1 and `frame_done` after 100 WAIT cycles; next frame start clears `timeout_err`. Same stimulus with the macro undefined → stays in WAIT indefinitely.
5. `resetn` pulsed low at beat 50 of a 256-point frame → outputs return immediately to reset values (`fft_npoint`=512), no `frame_done`; a new frame after reset starts at beat 1.
6. `freq_valid` coincident with the timeout cycle → `timeout_err`=0, `frame_done` issued once.
